// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state type, register-select values and command codes for the LCD bus driver
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    DONE
  } lcd_state_t;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] HOME       = 8'h02;
  localparam logic [7:0] FUNC_8B_1L = 8'h30;
  localparam logic [7:0] FUNC_8B_2L = 8'h38;
  localparam logic [7:0] FUNC_4B_1L = 8'h20;
  localparam logic [7:0] FUNC_4B_2L = 8'h28;

  // Clear and home are the only instructions the controller needs the long execution time for.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] code);
    return (rs == RS_CMD) && ((code == CLEAR) || (code == HOME));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter with zero flag, stalled by en
module lcd_timer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_value;
      end else if (count != '0) begin
        count <= count - WIDTH'(1);
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// rtl/lcd_bus_driver.sv - HD44780-style write-only bus sequencer driven by a one-cycle start request
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int T_SETUP     = 2,
  parameter int T_EN        = 13,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_data
);

  localparam int MAX_A = (T_SETUP > T_EN) ? T_SETUP : T_EN;
  localparam int MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_T = (MAX_C > T_EXEC_LONG) ? MAX_C : T_EXEC_LONG;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  lcd_state_t    state;
  logic          tmr_load;
  logic [CW-1:0] tmr_value;
  logic [CW-1:0] tmr_count;
  logic          tmr_zero;
  logic          unused_bits;

  assign unused_bits = ^{dataa[31:8], datab[31:1], tmr_count};
  assign lcd_rw      = 1'b0;

  // The counter is reloaded with the next state's duration on the same edge the state changes.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state)
      IDLE: begin
        tmr_load  = start;
        tmr_value = CW'(T_SETUP - 1);
      end
      SETUP: begin
        tmr_load  = tmr_zero;
        tmr_value = CW'(T_EN - 1);
      end
      PULSE: begin
        tmr_load  = tmr_zero;
        tmr_value = CW'(T_HOLD - 1);
      end
      HOLD: begin
        tmr_load  = tmr_zero;
        tmr_value = is_long_cmd(lcd_rs, lcd_data) ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
      end
      default: begin
        tmr_load  = 1'b0;
        tmr_value = '0;
      end
    endcase
  end

  lcd_timer #(
    .WIDTH(CW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .en         (clk_en),
    .load       (tmr_load),
    .load_value (tmr_value),
    .count      (tmr_count),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      result   <= '0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else if (clk_en) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            lcd_data <= dataa[7:0];
            lcd_rs   <= datab[0];
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tmr_zero) begin
            lcd_en <= 1'b1;
            state  <= PULSE;
          end
        end
        PULSE: begin
          if (tmr_zero) begin
            lcd_en <= 1'b0;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (tmr_zero) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (tmr_zero) begin
            done   <= 1'b1;
            result <= {24'h0, lcd_data};
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb/tb_lcd_bus_driver.sv - randomized and directed checks of lcd_bus_driver against a timeline model
module tb_lcd_bus_driver;

  localparam int TS  = 2;
  localparam int TE  = 3;
  localparam int TH  = 2;
  localparam int TX  = 10;
  localparam int TXL = 40;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [31:0] dataa, datab;
  logic        done, lcd_rs, lcd_rw, lcd_en;
  logic [31:0] result;
  logic [7:0]  lcd_data;

  int checks   = 0;
  int failures = 0;

  // Model: a transfer is a timeline of enabled edges k = 0..total since the accepting edge.
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_total = 0;
  logic [7:0]  m_byte = 8'h00;
  logic        m_rs = 1'b0;
  logic [31:0] m_result = 32'h0;

  lcd_bus_driver #(
    .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TXL)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .done(done), .result(result),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_busy = 1'b0; m_k = 0; m_byte = 8'h00; m_rs = 1'b0; m_result = 32'h0;
    end else if (clk_en) begin
      if (m_busy) begin
        m_k++;
        if (m_k == m_total) m_result = {24'h0, m_byte};
        if (m_k > m_total) m_busy = 1'b0;
      end else if (start) begin
        m_busy  = 1'b1;
        m_k     = 0;
        m_byte  = dataa[7:0];
        m_rs    = datab[0];
        m_total = TS + TE + TH +
                  ((m_rs == 1'b0 && (m_byte == 8'h01 || m_byte == 8'h02)) ? TXL : TX);
      end
    end
  endtask

  task automatic cycle(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic ce, input logic r);
    start = s; dataa = a; datab = b; clk_en = ce; reset = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("lcd_en", lcd_en, m_busy && m_k >= TS && m_k < TS + TE);
    chk("done", done, m_busy && m_k == m_total);
    chk("result", result, m_result);
    chk("lcd_data", lcd_data, m_byte);
    chk("lcd_rs", lcd_rs, m_rs);
    chk("lcd_rw", lcd_rw, 1'b0);
  endtask

  task automatic txn_latency(input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                             input string tag);
    int n;
    n = 0;
    cycle(1'b1, a, b, 1'b1, 1'b0);
    while (n < 200 && !done) begin
      cycle(1'b0, $urandom, $urandom, 1'b1, 1'b0);
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_result"}, result, {24'h0, a[7:0]});
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk({tag, "_result_held"}, result, {24'h0, a[7:0]});
  endtask

  initial begin
    int pulses, en_cnt, lat;
    logic prev_done;

    repeat (3) cycle(1'b1, 32'h38, 32'h0, 1'b0, 1'b1);
    chk("reset_done", done, 1'b0);
    chk("reset_result", result, 32'h0);
    chk("reset_data", lcd_data, 8'h00);
    repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    txn_latency(32'h38, 32'h0, 17, "func_8b_2l");
    txn_latency(32'h01, 32'h0, 47, "clear");
    txn_latency(32'h141, 32'h1, 17, "char_a");
    chk("char_a_rs", lcd_rs, 1'b1);
    txn_latency(32'h01, 32'h1, 17, "data_01_short");

    // Starts during WAIT and during the done cycle must both be dropped.
    cycle(1'b1, 32'h28, 32'h0, 1'b1, 1'b0);
    pulses = 0; prev_done = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      cycle((n == 10) || prev_done, (n == 10) ? 32'h55 : 32'h66, 32'h1, 1'b1, 1'b0);
      prev_done = done;
      if (done) pulses++;
    end
    chk("ignored_starts_pulses", pulses, 1);
    chk("ignored_starts_data", lcd_data, 8'h28);

    // Five stalled cycles inside PULSE stretch the strobe and delay done by five.
    cycle(1'b1, 32'h30, 32'h0, 1'b1, 1'b0);
    en_cnt = 0; lat = -1;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      cycle(1'b0, 32'h0, 32'h0, !(n >= 3 && n <= 7), 1'b0);
      if (lcd_en) en_cnt++;
      if (done) lat = n;
    end
    chk("stall_en_clocks", en_cnt, 8);
    chk("stall_latency", lat, 22);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset in the middle of PULSE.
    cycle(1'b1, 32'h38, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pre_reset_en", lcd_en, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("mid_reset_en", lcd_en, 1'b0);
    chk("mid_reset_result", result, 32'h0);
    chk("mid_reset_data", lcd_data, 8'h00);
    pulses = 0;
    repeat (60) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (done) pulses++;
    end
    chk("mid_reset_no_done", pulses, 0);
    txn_latency(32'h02, 32'h0, 47, "home_after_reset");

    // Random traffic with stalls, stray starts and occasional resets.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int guard;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[7:0] = 8'($urandom_range(1, 2));
      cycle(1'b1, a, $urandom, ($urandom_range(0, 9) != 0), 1'b0);
      guard = 0;
      while (m_busy && guard < 500) begin
        cycle(($urandom_range(0, 4) == 0), $urandom, $urandom,
              ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0));
        guard++;
      end
      if (guard >= 500) chk("random_guard", guard, 0);
      repeat ($urandom_range(0, 3)) cycle(1'b0, $urandom, $urandom, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_bus_driver.md
LCD_BUS_DRIVER -- requirements
Module: lcd_bus_driver

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  T_SETUP, 2, cycles RS/RW/DB are stable before EN rises.
  T_EN, 13, cycles EN is held high.
  T_HOLD, 2, cycles RS/RW/DB are held after EN falls.
  T_EXEC, 2000, wait cycles after a normal write (40 us at 50 MHz).
  T_EXEC_LONG, 82000, wait cycles after clear/home (1.64 ms at 50 MHz).
REQ-002 Ports SHALL be, one per line as name  direction  width  meaning:
  clk  in  1  single clock.
  reset  in  1  synchronous, active-high reset.
  clk_en  in  1  when low, all state, counters and outputs freeze.
  start  in  1  one-cycle request, custom-instruction style.
  dataa  in  32  bits[7:0] are the byte to write; bits[31:8] are ignored.
  datab  in  32  bit0 is RS (0 = command, 1 = character data); bits[31:1] are ignored.
  done  out  1  one-cycle completion pulse.
  result  out  32  {24'h0, byte written}, valid while done=1.
  lcd_rs  out  1  LCD register select.
  lcd_rw  out  1  LCD read/write; always 0.
  lcd_en  out  1  LCD enable strobe.
  lcd_data  out  8  LCD data bus.
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, WAIT and DONE.
REQ-005 In IDLE with clk_en=1 and start=1, the block SHALL latch dataa[7:0] and datab[0], drive them on lcd_data/lcd_rs, and enter SETUP at that edge.
REQ-006 Each state SHALL last exactly its parameter count of enabled cycles: SETUP T_SETUP, PULSE T_EN, HOLD T_HOLD, WAIT T_EXEC or T_EXEC_LONG; DONE SHALL last 1 cycle and then return to IDLE.
REQ-007 lcd_en SHALL be 1 only in PULSE; lcd_rs/lcd_data SHALL stay constant from SETUP through HOLD and SHALL be held until the next start.
REQ-008 WAIT SHALL use T_EXEC_LONG when RS=0 and the byte is 8'h01 or 8'h02, and T_EXEC otherwise.
REQ-009 Latency: with start sampled at edge 0, done SHALL be high for exactly the one cycle following edge T_SETUP+T_EN+T_HOLD+Twait.
REQ-010 result SHALL equal {24'h0, latched byte} while done=1 and hold its value afterwards.
REQ-011 start outside IDLE SHALL be ignored, with no queuing and no effect on the latched byte.
REQ-012 start and done in the same cycle (DONE state) SHALL ignore start; a new request is accepted only in IDLE.
REQ-013 When clk_en=0, the FSM, the counter and all outputs SHALL hold; a done pulse spanning clk_en=0 SHALL stay high until the next enabled edge.
REQ-014 The cycle counter SHALL be a down-counter wide enough for T_EXEC_LONG (17 bits at the defaults), loaded with parameter-1 on state entry; the state advances when it reads 0.

Reset
REQ-015 reset=1 at a clock edge SHALL force IDLE, done=0, result=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00 and counter=0, independent of clk_en.
REQ-016 A reset mid-transfer, including during PULSE, SHALL drop lcd_en at that edge and SHALL produce no done pulse.

Structure
REQ-017 Package lcd_pkg SHALL hold the state enum, RS_CMD/RS_DATA constants and the command codes CLEAR=8'h01, HOME=8'h02, FUNC_8B_1L=8'h30, FUNC_8B_2L=8'h38, FUNC_4B_1L=8'h20 and FUNC_4B_2L=8'h28.
REQ-018 One sub-module, lcd_timer (loadable down-counter with a zero flag and enable), SHALL be instantiated once.

Verification (bench parameters: T_SETUP=2, T_EN=3, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=40)
REQ-019 start with dataa=0x38, datab=0 -> lcd_rs=0, lcd_data=0x38, lcd_en high for 3 cycles starting 2 cycles after start, done pulse after edge 17, result=0x00000038.
REQ-020 start with dataa=0x01, datab=0 -> long wait; done pulse after edge 47, result=0x00000001.
REQ-021 start with dataa=0x141, datab=1 -> lcd_rs=1, lcd_data=0x41, done after edge 17, result=0x00000041.
REQ-022 A second start during WAIT, and a start during the done cycle -> both ignored; exactly one done pulse; lcd_data unchanged.
REQ-023 clk_en held low for 5 cycles inside PULSE -> lcd_en stays high 3 enabled cycles (8 clocks total) and done is delayed by exactly 5 cycles.
REQ-024 reset asserted during PULSE -> lcd_en=0 at the next edge, all outputs at reset values, no done pulse; a following start with 0x02 completes normally after edge 47.
